// File: rtl/seven_seg_scan_drv.sv
// rtl/seven_seg_scan_drv.sv - multiplexed 7-segment scan driver with hex decode, blanking, blink and leading-zero suppression
module seven_seg_scan_drv #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dig_en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              dec_ddp,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int KW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]             r_c;
  logic [KW-1:0]             r_k;
  logic [FW-1:0]             r_fc;
  logic                      r_phase;
  logic [4*NUM_DIGITS-1:0]   r_dig;
  logic [NUM_DIGITS-1:0]     r_en;
  logic [NUM_DIGITS-1:0]     r_dp;
  logic [NUM_DIGITS-1:0]     r_blk;

  logic                      w_slot_end;
  logic                      w_last_digit;
  logic                      w_blank;
  logic [3:0]                w_nib;
  logic                      w_en;
  logic                      w_dp;
  logic                      w_blk;
  logic                      w_lzu;
  logic                      w_acc;
  logic [NUM_DIGITS-1:0]     w_lz_upper;
  logic                      w_lz_blank;
  logic                      w_visible;
  logic [NUM_DIGITS-1:0]     w_an_on;

  // Hex nibble to {a,b,c,d,e,f,g}, active-high segments
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'h7E;
      4'h1: f_seg = 7'h30;
      4'h2: f_seg = 7'h6D;
      4'h3: f_seg = 7'h79;
      4'h4: f_seg = 7'h33;
      4'h5: f_seg = 7'h5B;
      4'h6: f_seg = 7'h5F;
      4'h7: f_seg = 7'h70;
      4'h8: f_seg = 7'h7F;
      4'h9: f_seg = 7'h7B;
      4'hA: f_seg = 7'h77;
      4'hB: f_seg = 7'h1F;
      4'hC: f_seg = 7'h4E;
      4'hD: f_seg = 7'h3D;
      4'hE: f_seg = 7'h4F;
      default: f_seg = 7'h47;
    endcase
  endfunction

  assign w_slot_end   = (r_c == CW'(REFRESH_DIV - 1));
  assign w_last_digit = (r_k == KW'(NUM_DIGITS - 1));
  assign w_an_on      = ~(NUM_DIGITS'(1) << r_k);

  // The anti-ghosting window collapses to nothing when BLANK_CYC is zero
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_c < CW'(BLANK_CYC));
    end
  endgenerate

  // Slot prescaler, digit index, frame counter and blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c     <= '0;
      r_k     <= '0;
      r_fc    <= '0;
      r_phase <= 1'b0;
    end else if (w_slot_end) begin
      r_c <= '0;
      if (w_last_digit) begin
        r_k <= '0;
        if (r_fc == FW'(BLINK_FRAMES - 1)) begin
          r_fc    <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fc <= r_fc + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end else begin
      r_c <= r_c + 1'b1;
    end
  end

  // Shadow copy of the per-digit inputs, captured on the load strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dig <= '0;
      r_en  <= '0;
      r_dp  <= '0;
      r_blk <= '0;
    end else if (load) begin
      r_dig <= digits_in;
      r_en  <= dig_en_in;
      r_dp  <= dp_in;
      r_blk <= blink_in;
    end
  end

  // For each digit: are it and every digit above it zero (disabled digits ignored)
  always_comb begin
    w_acc      = 1'b1;
    w_lz_upper = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      w_acc         = w_acc & (~r_en[j] | (r_dig[4*j +: 4] == 4'h0));
      w_lz_upper[j] = w_acc;
    end
  end

  // Pick out the attributes of the digit currently being scanned
  always_comb begin
    w_nib = 4'h0;
    w_en  = 1'b0;
    w_dp  = 1'b0;
    w_blk = 1'b0;
    w_lzu = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (r_k == KW'(j)) begin
        w_nib = r_dig[4*j +: 4];
        w_en  = r_en[j];
        w_dp  = r_dp[j];
        w_blk = r_blk[j];
        w_lzu = w_lz_upper[j];
      end
    end
  end

  assign w_lz_blank = lz_suppress & w_lzu & (r_k != '0);
  assign w_visible  = w_en & ~(w_blk & r_phase) & ~w_lz_blank;

  // Registered pin drive: one digit lit outside the blanking window, otherwise dark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= '1;
      dec_ddp    <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_slot_end & w_last_digit;
      if (!w_blank && w_visible) begin
        an      <= w_an_on;
        dec_ddp <= ~{f_seg(w_nib), w_dp};
      end else begin
        an      <= '1;
        dec_ddp <= 8'hFF;
      end
    end
  end

endmodule
